// File: rtl/search_ctrl.sv
// ---------------------------------------------------------------------------
// search_ctrl
//
// Job controller that sequences one search-system instance for a host.
// A job (seed, target metric, search-cycle budget) is latched on an accepted
// start. The system is then released from reset, allowed to warm up, and its
// progress is monitored. The best metric and the message that produced it
// are retained across restarts. When progress stalls the system is reseeded
// (golden-ratio seed step) and restarted. The job ends when the target
// metric is reached or the search-cycle budget runs out.
//
// Ports:
//   clk_i          clock
//   reset_ni       asynchronous active-low reset
//   start_i        job request, only sampled while idle
//   seed_i         initial system seed, latched on accepted start
//   target_i       required metric, latched on accepted start
//   budget_i       search-cycle budget, latched on accepted start (0 = none)
//   busy_o         job in progress (accepted start until the done cycle ends)
//   done_o         one-cycle pulse at job end
//   hit_o          job ended because the target was reached
//   best_o         best metric seen this job
//   best_msg_o     message that produced best_o
//   reseeds_o      reseed count this job, saturating
//   sys_reset_no   system reset (active low), registered
//   sys_seed_o     system seed, stable while the system is out of reset
//   sys_progress_i system progress metric
//   sys_msg_i      system message
// ---------------------------------------------------------------------------
module search_ctrl #(
  parameter int MSG     = 512,
  parameter int PW      = 9,
  parameter int WARM    = 358,
  parameter int STALL   = 1024,
  parameter int RST_LEN = 2
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  input  logic           start_i,
  input  logic [31:0]    seed_i,
  input  logic [PW-1:0]  target_i,
  input  logic [31:0]    budget_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           hit_o,
  output logic [PW-1:0]  best_o,
  output logic [MSG-1:0] best_msg_o,
  output logic [15:0]    reseeds_o,
  output logic           sys_reset_no,
  output logic [31:0]    sys_seed_o,
  input  logic [PW-1:0]  sys_progress_i,
  input  logic [MSG-1:0] sys_msg_i
);

  // One timer serves both the reset-hold and warm-up phases.
  localparam int TMAX = (WARM > RST_LEN) ? WARM : RST_LEN;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(STALL + 1);

  localparam logic [31:0] GOLDEN = 32'h9E37_79B9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_WARM,
    S_SEARCH,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [31:0]     bcnt_q, bcnt_d;
  logic [31:0]     budget_q, budget_d;
  logic [PW-1:0]   target_q, target_d;
  logic [31:0]     seed_q, seed_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            hit_q, hit_d;
  logic [PW-1:0]   best_q, best_d;
  logic [MSG-1:0]  msg_q, msg_d;
  logic [15:0]     reseeds_q, reseeds_d;
  logic            sys_rst_n_q, sys_rst_n_d;

  logic [31:0]     bcnt_nxt;
  logic [SW-1:0]   stall_nxt;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    stall_d     = stall_q;
    bcnt_d      = bcnt_q;
    budget_d    = budget_q;
    target_d    = target_q;
    seed_d      = seed_q;
    done_d      = 1'b0;
    hit_d       = hit_q;
    best_d      = best_q;
    msg_d       = msg_q;
    reseeds_d   = reseeds_q;
    bcnt_nxt    = bcnt_q + 32'd1;
    stall_nxt   = stall_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          target_d  = target_i;
          budget_d  = budget_i;
          seed_d    = seed_i;
          best_d    = '0;
          msg_d     = '0;
          hit_d     = 1'b0;
          reseeds_d = '0;
          bcnt_d    = '0;
          stall_d   = '0;
          tmr_d     = '0;
          state_d   = S_RST;
        end
      end

      S_RST: begin
        if (tmr_q == TW'(RST_LEN - 1)) begin
          tmr_d   = '0;
          state_d = S_WARM;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      S_WARM: begin
        if (tmr_q == TW'(WARM - 1)) begin
          tmr_d   = '0;
          state_d = S_SEARCH;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      S_SEARCH: begin
        bcnt_d = bcnt_nxt;
        // Improvement is always judged against the retained best, since the
        // system's own progress restarts from zero after every reseed.
        if (sys_progress_i > best_q) begin
          best_d    = sys_progress_i;
          msg_d     = sys_msg_i;
          stall_nxt = '0;
        end else begin
          stall_nxt = stall_q + SW'(1);
        end
        stall_d = stall_nxt;

        // Target beats budget beats stall; the best update above still lands.
        if (sys_progress_i >= target_q) begin
          hit_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if ((budget_q != '0) && (bcnt_nxt == budget_q)) begin
          hit_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (stall_nxt == SW'(STALL)) begin
          seed_d = seed_q + GOLDEN;
          if (reseeds_q != '1) begin
            reseeds_d = reseeds_q + 16'd1;
          end
          stall_d = '0;
          tmr_d   = '0;
          state_d = S_RST;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs are derived from the state being entered.
    busy_d      = (state_d != S_IDLE);
    sys_rst_n_d = (state_d == S_WARM) || (state_d == S_SEARCH);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      stall_q     <= '0;
      bcnt_q      <= '0;
      budget_q    <= '0;
      target_q    <= '0;
      seed_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      best_q      <= '0;
      msg_q       <= '0;
      reseeds_q   <= '0;
      sys_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      stall_q     <= stall_d;
      bcnt_q      <= bcnt_d;
      budget_q    <= budget_d;
      target_q    <= target_d;
      seed_q      <= seed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      best_q      <= best_d;
      msg_q       <= msg_d;
      reseeds_q   <= reseeds_d;
      sys_rst_n_q <= sys_rst_n_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign hit_o        = hit_q;
  assign best_o       = best_q;
  assign best_msg_o   = msg_q;
  assign reseeds_o    = reseeds_q;
  assign sys_reset_no = sys_rst_n_q;
  assign sys_seed_o   = seed_q;

endmodule
